// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between core and host.
// Ports: core_*/host_* request+response, mem_* memory port, busy status.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_gnt,
  output logic                  core_rvalid,
  output logic [DATA_WIDTH-1:0] core_rdata,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t state;
  state_t state_nx;

  // ptr: 0 = core holds priority, 1 = host
  logic ptr;
  // owner: 0 = core, 1 = host
  logic owner;
  logic cap_we;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;

  logic any_req;
  logic win_host;
  logic sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  always_comb begin
    any_req  = core_req | host_req;
    win_host = 1'b0;
    unique case (1'b1)
      (core_req & host_req):  win_host = ptr;
      (host_req & ~core_req): win_host = 1'b1;
      default:                win_host = 1'b0;
    endcase
  end

  always_comb begin
    sel_we    = core_we;
    sel_addr  = core_addr;
    sel_wdata = core_wdata;
    if (win_host) begin
      sel_we    = host_we;
      sel_addr  = host_addr;
      sel_wdata = host_wdata;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_req) state_nx = ISSUE;
      ISSUE:   state_nx = cap_we ? IDLE : RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Request capture: the issued access never sees live inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner     <= 1'b0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (state == IDLE && any_req) begin
      owner     <= win_host;
      cap_we    <= sel_we;
      cap_addr  <= sel_addr;
      cap_wdata <= sel_wdata;
    end
  end

  // Priority passes to the other side once an access is issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= 1'b0;
    end else if (state == ISSUE) begin
      ptr <= ~owner;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_rvalid <= 1'b0;
      host_rvalid <= 1'b0;
      core_rdata  <= '0;
      host_rdata  <= '0;
    end else begin
      core_rvalid <= (state == RESP) & ~owner;
      host_rvalid <= (state == RESP) & owner;
      if (state == RESP) begin
        if (owner) host_rdata <= mem_rdata;
        else       core_rdata <= mem_rdata;
      end
    end
  end

  assign mem_en    = (state == ISSUE);
  assign mem_we    = (state == ISSUE) & cap_we;
  assign mem_addr  = cap_addr;
  assign mem_wdata = cap_wdata;
  assign core_gnt  = (state == ISSUE) & ~owner;
  assign host_gnt  = (state == ISSUE) & owner;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter.
// Includes a small synchronous memory model behind the mem_* port.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        core_req = 1'b0;
  logic        core_we = 1'b0;
  logic [31:0] core_addr = '0;
  logic [31:0] core_wdata = '0;
  logic        core_gnt;
  logic        core_rvalid;
  logic [31:0] core_rdata;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [31:0] host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic        host_gnt;
  logic        host_rvalid;
  logic [31:0] host_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  logic [31:0] mem [0:63];

  int n_chk = 0;
  int n_err = 0;

  dmem_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_gnt   (core_gnt),
    .core_rvalid(core_rvalid),
    .core_rdata (core_rdata),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:2]];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_en"}, {31'd0, mem_en}, 0);
    chk({tag, "_we"}, {31'd0, mem_we}, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_cgnt"}, {31'd0, core_gnt}, 0);
    chk({tag, "_hgnt"}, {31'd0, host_gnt}, 0);
    chk({tag, "_crv"}, {31'd0, core_rvalid}, 0);
    chk({tag, "_hrv"}, {31'd0, host_rvalid}, 0);
    chk({tag, "_crd"}, core_rdata, 0);
    chk({tag, "_hrd"}, host_rdata, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  initial begin
    int ng;
    int cyc;
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE0000 + i;

    // reset state
    #1;
    chk_zero("rst0");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // host read 0x40, reset hits during RESP
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = 32'h40;
    tick();
    chk("h40_gnt", {31'd0, host_gnt}, 1);
    chk("h40_addr", mem_addr, 32'h40);
    host_req = 1'b0;
    tick();
    chk("h40_resp_busy", {31'd0, busy}, 1);
    rst = 1'b0;
    #1;
    chk_zero("rst_resp");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_hrv", {31'd0, host_rvalid}, 0);
    end

    // core-only write 0x10
    core_req   = 1'b1;
    core_we    = 1'b1;
    core_addr  = 32'h10;
    core_wdata = 32'hDEADBEEF;
    tick();
    chk("cw_gnt", {31'd0, core_gnt}, 1);
    chk("cw_en", {31'd0, mem_en}, 1);
    chk("cw_we", {31'd0, mem_we}, 1);
    chk("cw_addr", mem_addr, 32'h10);
    chk("cw_wdata", mem_wdata, 32'hDEADBEEF);
    core_req = 1'b0;
    tick();
    chk("cw_busy", {31'd0, busy}, 0);
    chk("cw_gnt_off", {31'd0, core_gnt}, 0);

    // core read 0x10
    core_req = 1'b1;
    core_we  = 1'b0;
    tick();
    chk("cr_gnt", {31'd0, core_gnt}, 1);
    chk("cr_we", {31'd0, mem_we}, 0);
    core_req = 1'b0;
    tick();
    chk("cr_rv_early", {31'd0, core_rvalid}, 0);
    tick();
    chk("cr_rv", {31'd0, core_rvalid}, 1);
    chk("cr_rdata", core_rdata, 32'hDEADBEEF);
    chk("cr_hrdata", host_rdata, 0);
    tick();
    chk("cr_rv_pulse", {31'd0, core_rvalid}, 0);

    // both request from reset
    do_reset();
    core_req   = 1'b1;
    core_we    = 1'b0;
    core_addr  = 32'h00;
    host_req   = 1'b1;
    host_we    = 1'b1;
    host_addr  = 32'h04;
    host_wdata = 32'h12345678;
    tick();
    chk("bt_cgnt", {31'd0, core_gnt}, 1);
    chk("bt_hgnt0", {31'd0, host_gnt}, 0);
    chk("bt_addr0", mem_addr, 32'h00);
    core_we    = 1'b1;
    core_addr  = 32'h08;
    core_wdata = 32'h00000055;
    tick();
    chk("bt_resp", {31'd0, core_gnt | host_gnt}, 0);
    tick();
    chk("bt_crv", {31'd0, core_rvalid}, 1);
    chk("bt_crd", core_rdata, 32'hC0DE0000);
    tick();
    chk("bt_hgnt", {31'd0, host_gnt}, 1);
    chk("bt_cwait", {31'd0, core_gnt}, 0);
    chk("bt_haddr", mem_addr, 32'h04);
    chk("bt_hwd", mem_wdata, 32'h12345678);
    host_req = 1'b0;
    tick();
    tick();
    chk("bt_cgnt2", {31'd0, core_gnt}, 1);
    chk("bt_caddr2", mem_addr, 32'h08);
    core_req = 1'b0;
    tick();

    // continuous requests: strict alternation
    do_reset();
    core_req   = 1'b1;
    core_we    = 1'b1;
    core_addr  = 32'h20;
    core_wdata = 32'h11110020;
    host_req   = 1'b1;
    host_we    = 1'b1;
    host_addr  = 32'h24;
    host_wdata = 32'h22220024;
    ng  = 0;
    cyc = 0;
    while (ng < 8 && cyc < 40) begin
      tick();
      cyc++;
      if (core_gnt || host_gnt) begin
        chk("rr_both", {31'd0, core_gnt & host_gnt}, 0);
        chk("rr_seq", {31'd0, host_gnt}, ng % 2);
        ng++;
      end
    end
    chk("rr_cnt", ng, 8);
    core_req = 1'b0;
    host_req = 1'b0;
    tick();
    tick();

    // host address changes after capture
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = 32'h20;
    tick();
    chk("ha_gnt", {31'd0, host_gnt}, 1);
    chk("ha_addr", mem_addr, 32'h20);
    host_addr = 32'h30;
    tick();
    chk("ha_hold", mem_addr, 32'h20);
    tick();
    chk("ha_rv", {31'd0, host_rvalid}, 1);
    chk("ha_rd", host_rdata, 32'h11110020);
    tick();
    chk("ha_gnt2", {31'd0, host_gnt}, 1);
    chk("ha_addr2", mem_addr, 32'h30);
    host_req = 1'b0;
    tick();
    tick();
    chk("ha_rv2", {31'd0, host_rvalid}, 1);
    chk("ha_rd2", host_rdata, 32'hC0DE000C);
    chk("ha_crd", core_rdata, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
